// File: rtl/inst_issue_queue_if.sv
// inst_issue_queue_if: fetch-push / issue-pop bundle of the instruction issue queue
interface inst_issue_queue_if #(parameter int AW = 3);
  logic          push_valid_1;
  logic          push_valid_2;
  logic [31:0]   push_pc_1;
  logic [31:0]   push_pc_2;
  logic [31:0]   push_inst_1;
  logic [31:0]   push_inst_2;
  logic          push_ready;
  logic          flush;
  logic          pop_1;
  logic          pop_2;
  logic          out_valid_1;
  logic          out_valid_2;
  logic [31:0]   out_pc_1;
  logic [31:0]   out_pc_2;
  logic [31:0]   out_inst_1;
  logic [31:0]   out_inst_2;
  logic [AW:0]   count;
  modport slave (
    input  push_valid_1, push_valid_2, push_pc_1, push_pc_2, push_inst_1, push_inst_2,
    input  flush, pop_1, pop_2,
    output push_ready, out_valid_1, out_valid_2, out_pc_1, out_pc_2, out_inst_1, out_inst_2, count
  );
  modport master (
    output push_valid_1, push_valid_2, push_pc_1, push_pc_2, push_inst_1, push_inst_2,
    output flush, pop_1, pop_2,
    input  push_ready, out_valid_1, out_valid_2, out_pc_1, out_pc_2, out_inst_1, out_inst_2, count
  );
endinterface

// File: rtl/inst_issue_queue.sv
// inst_issue_queue: dual-push circular instruction queue; dual pop when ISSUE_QUEUE_DUAL_POP_EN is defined
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  inst_issue_queue_if.slave q
);
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] rp, wp, rp1, wp1;
  logic [AW:0]   cnt;
  logic          push_ok, ov1, ov2;
  logic [1:0]    push_n, pop_n;
  assign rp1           = rp + AW'(1);
  assign wp1           = wp + AW'(1);
  assign q.push_ready  = cnt <= (AW+1)'(DEPTH - 2);
  assign push_ok       = q.push_ready & q.push_valid_1 & ~q.flush;
  assign push_n        = push_ok ? (q.push_valid_2 ? 2'd2 : 2'd1) : 2'd0;
  assign ov1           = cnt != '0;
`ifdef ISSUE_QUEUE_DUAL_POP_EN
  assign ov2           = cnt >= (AW+1)'(2);
`else
  assign ov2           = 1'b0;
`endif
  assign pop_n         = (!q.pop_1 || !ov1) ? 2'd0 : (q.pop_2 && ov2) ? 2'd2 : 2'd1;
  assign q.out_valid_1 = ov1;
  assign q.out_valid_2 = ov2;
  assign q.out_pc_1    = pc_mem[rp];
  assign q.out_inst_1  = inst_mem[rp];
  assign q.out_pc_2    = pc_mem[rp1];
  assign q.out_inst_2  = inst_mem[rp1];
  assign q.count       = cnt;
  // entry storage: slot 1 at wp, slot 2 at wp+1; not reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wp]   <= q.push_pc_1;
      inst_mem[wp] <= q.push_inst_1;
      if (q.push_valid_2) begin
        pc_mem[wp1]   <= q.push_pc_2;
        inst_mem[wp1] <= q.push_inst_2;
      end
    end
  end
  // pointers and occupancy; flush wins over same-cycle push and pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (q.flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      rp  <= rp + AW'(pop_n);
      wp  <= wp + AW'(push_n);
      cnt <= cnt + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end
endmodule
